// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b types for the memory-port arbiter: word/mask aliases and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_RECOVER = 2'd3
  } arb_state_t;

  localparam lc3b_mem_wmask FETCH_WMASK = 2'b11;
  localparam lc3b_word      WORD_ZERO   = 16'h0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-side signals around the shared memory port.
interface mem_port_arbiter_if;
  import lc3b_types::*;

  logic          i_read;
  lc3b_word      i_addr;
  logic          i_resp;
  lc3b_word      i_rdata;
  logic          d_read;
  logic          d_write;
  lc3b_word      d_addr;
  lc3b_word      d_wdata;
  lc3b_mem_wmask d_wmask;
  logic          d_resp;
  lc3b_word      d_rdata;
  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_addr;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_wmask;
  logic          mem_resp;
  lc3b_word      mem_rdata;
  logic          busy;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           mem_wmask, busy
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           mem_wmask, busy
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter of data grants made while a fetch waits; hit_o forces the next grant to fetch.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage; data has priority
// unless fetch has been starved STARVE_LIMIT times. Granted request is registered toward memory.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  port_if
);

  arb_state_t    state_q, state_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  lc3b_word      mem_addr_q, mem_addr_d;
  lc3b_word      mem_wdata_q, mem_wdata_d;
  lc3b_mem_wmask mem_wmask_q, mem_wmask_d;

  logic             idle_s;
  logic             d_req_s;
  logic             fetch_win_s;
  logic             data_win_s;
  logic             starve_hit_s;
  logic [CNT_W-1:0] starve_cnt_s;

  assign idle_s      = (state_q == ARB_IDLE);
  assign d_req_s     = port_if.d_read | port_if.d_write;
  assign fetch_win_s = idle_s & port_if.i_read & (~d_req_s | starve_hit_s);
  assign data_win_s  = idle_s & ~fetch_win_s & d_req_s;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc_i (data_win_s & port_if.i_read),
    .clr_i (idle_s & (fetch_win_s | ~port_if.i_read)),
    .cnt_o (starve_cnt_s),
    .hit_o (starve_hit_s)
  );

  // Write wins over read if a requester violates protocol by raising both.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    case (state_q)
      ARB_IDLE: begin
        if (fetch_win_s) begin
          state_d     = ARB_SERVE_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = port_if.i_addr;
          mem_wdata_d = WORD_ZERO;
          mem_wmask_d = FETCH_WMASK;
        end else if (data_win_s) begin
          state_d     = ARB_SERVE_D;
          mem_read_d  = ~port_if.d_write;
          mem_write_d = port_if.d_write;
          mem_addr_d  = port_if.d_addr;
          mem_wdata_d = port_if.d_wdata;
          mem_wmask_d = port_if.d_wmask;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (port_if.mem_resp) begin
          state_d     = ARB_RECOVER;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ARB_RECOVER: state_d = ARB_IDLE;
      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= WORD_ZERO;
      mem_wdata_q <= WORD_ZERO;
      mem_wmask_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  // Responses are steered only to the current owner; mem_resp outside SERVE is dropped.
  assign port_if.i_resp    = (state_q == ARB_SERVE_I) & port_if.mem_resp;
  assign port_if.d_resp    = (state_q == ARB_SERVE_D) & port_if.mem_resp;
  assign port_if.i_rdata   = port_if.mem_rdata;
  assign port_if.d_rdata   = port_if.mem_rdata;
  assign port_if.mem_read  = mem_read_q;
  assign port_if.mem_write = mem_write_q;
  assign port_if.mem_addr  = mem_addr_q;
  assign port_if.mem_wdata = mem_wdata_q;
  assign port_if.mem_wmask = mem_wmask_q;
  assign port_if.busy      = ~idle_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model of the port.
module tb_mem_port_arbiter;
  import lc3b_types::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .port_if (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: where the port is in a transaction (0 idle, 1 in service, 2 dead cycle) and what it holds.
  int          m_phase;
  bit          m_fetch;
  bit          m_rd, m_wr;
  logic [15:0] m_addr, m_wdata;
  logic [1:0]  m_wmask;
  int          m_starve;
  int          m_wait, m_target;

  bit auto_mem, spur;
  bit obs_i_resp, obs_d_resp;
  bit i_pend, d_pend;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_fetch = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    m_addr = 16'h0000; m_wdata = 16'h0000; m_wmask = 2'b00;
    m_starve = 0; m_wait = 0; m_target = 1;
  endtask

  task automatic model_step();
    bit has_d;
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      has_d = bus.d_read | bus.d_write;
      if (bus.i_read && (!has_d || m_starve == LIMIT)) begin
        m_fetch = 1'b1; m_rd = 1'b1; m_wr = 1'b0;
        m_addr = bus.i_addr; m_wdata = 16'h0000; m_wmask = 2'b11;
        m_starve = 0; m_phase = 1;
      end else if (has_d) begin
        m_fetch = 1'b0; m_wr = bus.d_write; m_rd = !bus.d_write;
        m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_wmask = bus.d_wmask;
        m_starve = bus.i_read ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        m_phase = 1;
      end else if (!bus.i_read) begin
        m_starve = 0;
      end
      if (m_phase == 1) begin
        m_wait = 0;
        m_target = $urandom_range(1, 3);
      end
    end else if (m_phase == 1) begin
      if (bus.mem_resp) begin
        m_phase = 2; m_rd = 1'b0; m_wr = 1'b0;
      end else begin
        m_wait++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare();
    bit serving;
    serving = (m_phase == 1);
    chk("mem_read", bus.mem_read, m_rd);
    chk("mem_write", bus.mem_write, m_wr);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("mem_wmask", bus.mem_wmask, m_wmask);
    chk("i_resp", bus.i_resp, serving && m_fetch && bus.mem_resp);
    chk("d_resp", bus.d_resp, serving && !m_fetch && bus.mem_resp);
    chk("i_rdata", bus.i_rdata, bus.mem_rdata);
    chk("d_rdata", bus.d_rdata, bus.mem_rdata);
    chk("busy", bus.busy, m_phase != 0);
    chk("starve_cnt", dut.u_starve.cnt_q, m_starve);
    obs_i_resp = bus.i_resp;
    obs_d_resp = bus.d_resp;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    if (auto_mem) begin
      if (m_phase == 1) bus.mem_resp = (m_wait >= m_target);
      else bus.mem_resp = spur && ($urandom_range(0, 7) == 0);
      bus.mem_rdata = 16'($urandom);
    end
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_drive();
    if (obs_i_resp) begin bus.i_read = 1'b0; i_pend = 1'b0; end
    if (obs_d_resp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; d_pend = 1'b0; end
    if (!i_pend && $urandom_range(0, 3) == 0) begin
      bus.i_read = 1'b1; bus.i_addr = 16'($urandom); i_pend = 1'b1;
    end
    if (!d_pend && $urandom_range(0, 2) == 0) begin
      bus.d_write = 1'($urandom); bus.d_read = !bus.d_write;
      bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom); bus.d_wmask = 2'($urandom);
      d_pend = 1'b1;
    end
  endtask

  initial begin
    int ndata;
    bit got_fetch, got_iresp;
    bus.i_read = 1'b0; bus.i_addr = 16'h0000;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 16'h0000;
    bus.d_wdata = 16'h0000; bus.d_wmask = 2'b00;
    bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0000;
    auto_mem = 1'b0; spur = 1'b0; obs_i_resp = 1'b0; obs_d_resp = 1'b0;
    model_reset();

    @(negedge clk); @(negedge clk); #1;
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wmask", bus.mem_wmask, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(negedge clk); reset = 1'b0;
    step();

    // Fetch only, memory answers on the third cycle after the grant.
    bus.i_read = 1'b1; bus.i_addr = 16'h0040;
    step();
    chk("f_mem_read", bus.mem_read, 1'b1);
    chk("f_mem_addr", bus.mem_addr, 16'h0040);
    chk("f_mem_wmask", bus.mem_wmask, 2'b11);
    chk("f_busy", bus.busy, 1'b1);
    step(); step();
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1234; #1;
    chk("f_i_resp", bus.i_resp, 1'b1);
    chk("f_i_rdata", bus.i_rdata, 16'h1234);
    chk("f_d_resp", bus.d_resp, 1'b0);
    step();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0; #1;
    chk("f_recover_busy", bus.busy, 1'b1);
    chk("f_recover_iresp", bus.i_resp, 1'b0);
    step();
    chk("f_idle_busy", bus.busy, 1'b0);

    // Simultaneous fetch and data write: data first.
    bus.i_read = 1'b1; bus.i_addr = 16'h0010;
    bus.d_write = 1'b1; bus.d_addr = 16'h2000; bus.d_wdata = 16'hBEEF; bus.d_wmask = 2'b01;
    step();
    chk("s_mem_write", bus.mem_write, 1'b1);
    chk("s_mem_read", bus.mem_read, 1'b0);
    chk("s_mem_addr", bus.mem_addr, 16'h2000);
    chk("s_mem_wdata", bus.mem_wdata, 16'hBEEF);
    chk("s_mem_wmask", bus.mem_wmask, 2'b01);
    step();
    bus.mem_resp = 1'b1; #1;
    chk("s_d_resp", bus.d_resp, 1'b1);
    chk("s_i_resp", bus.i_resp, 1'b0);
    step();
    bus.d_write = 1'b0; bus.mem_resp = 1'b0;
    step(); step();
    chk("s_fetch_read", bus.mem_read, 1'b1);
    chk("s_fetch_addr", bus.mem_addr, 16'h0010);
    chk("s_fetch_wmask", bus.mem_wmask, 2'b11);
    step();
    bus.mem_resp = 1'b1; step();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0; step(); step();

    // Requester address changes while in service.
    bus.d_read = 1'b1; bus.d_addr = 16'h3000;
    step();
    bus.d_addr = 16'h5555;
    step(); chk("st_addr_w1", bus.mem_addr, 16'h3000);
    step(); chk("st_addr_w2", bus.mem_addr, 16'h3000);
    bus.mem_resp = 1'b1; #1; chk("st_addr_resp", bus.mem_addr, 16'h3000);
    step();
    bus.d_read = 1'b0; bus.mem_resp = 1'b0; step(); step();

    // Spurious mem_resp in IDLE, then in RECOVER.
    bus.mem_resp = 1'b1; #1;
    chk("sp_idle_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    step(); chk("sp_idle_busy", bus.busy, 1'b0);
    bus.mem_resp = 1'b0; bus.i_read = 1'b1; bus.i_addr = 16'h0ABC;
    step(); step();
    bus.mem_resp = 1'b1; step();
    bus.i_read = 1'b0; #1;
    chk("sp_rec_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    step();
    chk("sp_rec_busy", bus.busy, 1'b0);
    chk("sp_rec_read", bus.mem_read, 1'b0);
    bus.mem_resp = 1'b0; step();

    // Starvation: both held, exactly LIMIT data transactions before fetch is forced.
    auto_mem = 1'b1; spur = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 16'h0100;
    bus.d_read = 1'b1; bus.d_addr = 16'h0200;
    ndata = 0; got_fetch = 1'b0;
    for (int c = 0; c < 200 && !got_fetch; c++) begin
      step();
      if (obs_d_resp) ndata++;
      if (bus.mem_read && bus.mem_addr == 16'h0100) got_fetch = 1'b1;
    end
    chk("starve_fetch_granted", got_fetch, 1'b1);
    chk("starve_data_count", ndata, 4);
    chk("starve_cnt_cleared", dut.u_starve.cnt_q, 4'd0);
    got_iresp = 1'b0;
    for (int c = 0; c < 50 && !got_iresp; c++) begin
      step();
      got_iresp = obs_i_resp;
    end
    chk("starve_fetch_done", got_iresp, 1'b1);
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    step(); step();

    // Asynchronous reset in the middle of a fetch.
    auto_mem = 1'b0; bus.mem_resp = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 16'h0777;
    step(); chk("r_granted", bus.mem_read, 1'b1);
    step();
    #2; reset = 1'b1; #1;
    chk("r_async_read", bus.mem_read, 1'b0);
    chk("r_async_busy", bus.busy, 1'b0);
    chk("r_async_addr", bus.mem_addr, 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0; bus.i_read = 1'b0; bus.mem_resp = 1'b1; #1;
    chk("r_late_resp", bus.i_resp, 1'b0);
    step();
    bus.mem_resp = 1'b0; bus.i_read = 1'b1; bus.i_addr = 16'h0888;
    step();
    chk("r_new_read", bus.mem_read, 1'b1);
    chk("r_new_addr", bus.mem_addr, 16'h0888);

    // Randomized traffic with spurious responses against the model.
    auto_mem = 1'b1; spur = 1'b1;
    i_pend = bus.i_read; d_pend = 1'b0; obs_i_resp = 1'b0; obs_d_resp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
